hex_display_mux: RTL and testbench

Time-multiplexed driver for a bank of DIGITS common-segment 7-segment displays. It captures a packed hex value on a load strobe and commits it to the display only at frame boundaries, so no tearing is visible. It scans one digit at a time at a parametrised rate and decodes the full hex range 0–F. It sits between the FIFO status/data logic and the board display pins, and replaces per-digit combinational decoders.

---
 rtl/hex_display_mux.sv | 214 +++++++++++++++++++++
 tb/tb_hex_display_mux.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_mux.sv
// hex_display_mux
// Time-multiplexed driver for a bank of common-segment 7-segment displays.
// A packed hex value is captured on a load strobe into a shadow register and
// committed to the active register only at frame boundaries, so a digit never
// shows a mix of old and new data within one scan. One digit is lit at a time
// for SCAN_DIV clock cycles; the full hex range 0-F is decoded.
//
// Optional feature, selected at build time:
//   LEADING_ZERO_BLANK_EN - blank digits above the most significant nonzero
//                           nibble (digit 0 is never blanked).
//
// Outputs seg/dp/an/frame are registered. seg/dp/an are computed from the
// digit index and active register of the previous cycle. frame is delayed so
// that it rises in the same cycle that an returns to digit 0.

module hex_display_mux #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    // Counter widths; a single-value counter still needs one bit.
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_STEP = PW'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [IW-1:0] IDX_STEP   = IW'(1);

    // Scan timing state
    logic [PW-1:0]          presc_reg, presc_next;
    logic [IW-1:0]          idx_reg, idx_next;
    logic                   wrap;
    logic                   boundary;

    // Load / commit state
    logic [4*DIGITS-1:0]    shadow_val_reg, shadow_val_next;
    logic [DIGITS-1:0]      shadow_dp_reg, shadow_dp_next;
    logic                   pending_reg, pending_next;
    logic [4*DIGITS-1:0]    active_val_reg, active_val_next;
    logic [DIGITS-1:0]      active_dp_reg, active_dp_next;
    logic                   commit;

    // Display path
    logic [3:0]             nibble [DIGITS];
    logic [DIGITS-1:0]      blank;
    logic [DIGITS-1:0]      an_next;
    logic [3:0]             cur_nibble;
    logic                   cur_dp;
    logic                   cur_blank;
    logic [6:0]             seg_next;
    logic                   dp_next;

    // Output registers
    logic [6:0]             seg_reg;
    logic                   dp_reg;
    logic [DIGITS-1:0]      an_reg;
    logic                   boundary_q_reg;
    logic                   frame_reg;

    // Hex nibble to active-high segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Prescaler and digit index: advance the digit on every prescaler wrap.
    always_comb begin
        wrap       = (presc_reg == PRESC_LAST);
        boundary   = wrap && (idx_reg == IDX_LAST);
        presc_next = wrap ? '0 : presc_reg + PRESC_STEP;
        idx_next   = idx_reg;
        if (wrap) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_STEP;
        end
    end

    // Shadow capture and frame-boundary commit; a load on the boundary
    // cycle bypasses the shadow so the newest value is never lost.
    always_comb begin
        shadow_val_next = shadow_val_reg;
        shadow_dp_next  = shadow_dp_reg;
        pending_next    = pending_reg;
        active_val_next = active_val_reg;
        active_dp_next  = active_dp_reg;
        commit          = boundary && (pending_reg || load);

        if (load) begin
            shadow_val_next = value;
            shadow_dp_next  = dp_mask;
        end

        if (commit) begin
            active_val_next = load ? value   : shadow_val_reg;
            active_dp_next  = load ? dp_mask : shadow_dp_reg;
            pending_next    = 1'b0;
        end else if (load) begin
            pending_next    = 1'b1;
        end
    end

    // Per-digit slices of the active value and one-hot digit enables.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nibble[gi]  = active_val_reg[4*gi +: 4];
            assign an_next[gi] = (idx_reg == IW'(gi));
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blanked when it and every digit above it are zero;
    // digit 0 always shows so that a zero value reads as "0".
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = (active_val_reg[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate
`else
    assign blank = '0;
`endif

    // Select the lit digit's nibble, decimal point and blanking, then decode.
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IW'(i)) begin
                cur_nibble = nibble[i];
                cur_dp     = active_dp_reg[i];
                cur_blank  = blank[i];
            end
        end
        seg_next = cur_blank ? 7'h00 : hex_to_seg(cur_nibble);
        dp_next  = cur_dp && !cur_blank;
    end

    // Scan, shadow and active state; reset discards any uncommitted load.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg      <= '0;
            idx_reg        <= '0;
            shadow_val_reg <= '0;
            shadow_dp_reg  <= '0;
            pending_reg    <= 1'b0;
            active_val_reg <= '0;
            active_dp_reg  <= '0;
        end else begin
            presc_reg      <= presc_next;
            idx_reg        <= idx_next;
            shadow_val_reg <= shadow_val_next;
            shadow_dp_reg  <= shadow_dp_next;
            pending_reg    <= pending_next;
            active_val_reg <= active_val_next;
            active_dp_reg  <= active_dp_next;
        end
    end

    // Registered pin drivers; frame is delayed a second stage so it lines
    // up with the first cycle that an shows digit 0 again.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg        <= 7'h00;
            dp_reg         <= 1'b0;
            an_reg         <= '0;
            boundary_q_reg <= 1'b0;
            frame_reg      <= 1'b0;
        end else begin
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
            boundary_q_reg <= boundary;
            frame_reg      <= boundary_q_reg;
        end
    end

    assign seg   = seg_reg;
    assign dp    = dp_reg;
    assign an    = an_reg;
    assign frame = frame_reg;

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed testbench for hex_display_mux with DIGITS=4, SCAN_DIV=4.
// Honours LEADING_ZERO_BLANK_EN when the bench is built with it defined.

module tb_hex_display_mux;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    // Segment pattern of a zero digit above the most significant nonzero one.
    localparam logic [6:0] ZSEG = BLANK ? 7'h00 : 7'h3F;
    localparam logic       ZDP  = !BLANK;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt;

    hex_display_mux #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .dp_mask (dp_mask),
        .load    (load),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One load transaction: strobe for a single cycle.
    task automatic do_load(input logic [15:0] v, input logic [3:0] m);
        value   = v;
        dp_mask = m;
        load    = 1'b1;
        tick(1);
        load    = 1'b0;
        $display("load value=%h dp_mask=%b at t=%0t", v, m, $time);
    endtask

    // Tick until frame is seen (bounded); returns the number of ticks taken.
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (frame !== 1'b1 && n < 40);
        check("frame_wait", {15'd0, frame}, 16'd1);
    endtask

    // Sync to a frame and check the first cycle of each digit in turn.
    task automatic show_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        int n;
        wait_frame(n);
        for (int d = 0; d < DIGITS; d++) begin
            if (d != 0) tick(SCAN_DIV);
            check($sformatf("%s_an%0d", tag, d),  {12'd0, an}, 16'(4'b0001 << d));
            check($sformatf("%s_seg%0d", tag, d), {9'd0, seg}, {9'd0, segs[7*d +: 7]});
            check($sformatf("%s_dp%0d", tag, d),  {15'd0, dp}, {15'd0, dps[d]});
        end
        $display("frame %s checked at t=%0t", tag, $time);
    endtask

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        value   = 16'h0000;
        dp_mask = 4'b0000;

        // Reset state
        tick(3);
        check("rst_an",    {12'd0, an},    16'h0000);
        check("rst_seg",   {9'd0, seg},    16'h0000);
        check("rst_dp",    {15'd0, dp},    16'h0000);
        check("rst_frame", {15'd0, frame}, 16'h0000);

        // First cycle after release shows digit 0 of a zero value
        rst = 1'b0;
        tick(1);
        check("first_an",    {12'd0, an},    16'h0001);
        check("first_seg",   {9'd0, seg},    16'h003F);
        check("first_dp",    {15'd0, dp},    16'h0000);
        check("first_frame", {15'd0, frame}, 16'h0000);
        tick(3);
        check("dig0_last_an", {12'd0, an}, 16'h0001);
        tick(1);
        check("dig1_an",  {12'd0, an},  16'h0002);
        check("dig1_seg", {9'd0, seg},  {9'd0, ZSEG});

        // Frame cadence: first frame 12 ticks from here, then every 16
        wait_frame(cnt);
        check("frame_first_gap", 16'(cnt), 16'd12);
        check("frame_an", {12'd0, an}, 16'h0001);
        wait_frame(cnt);
        check("frame_period", 16'(cnt), 16'd16);
        tick(1);
        check("frame_width", {15'd0, frame}, 16'h0000);

        // Mid-frame load: old value held until next boundary
        tick(4);
        do_load(16'hA5C3, 4'b0000);
        check("hold_old_an",  {12'd0, an}, 16'h0002);
        check("hold_old_seg", {9'd0, seg}, {9'd0, ZSEG});
        show_frame("a5c3", {7'h77, 7'h6D, 7'h39, 7'h4F}, 4'b0000);

        // Two loads in one frame: last one wins, 1111 never shown
        wait_frame(cnt);
        tick(2);
        do_load(16'h1111, 4'b0000);
        tick(3);
        do_load(16'h2222, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_assert++;
            assert (seg !== 7'h06) else begin
                n_fail++;
                $error("FAIL no_1111: observed %h expected not 06", seg);
            end
        end
        show_frame("2222", {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000);

        // Load exactly on the boundary cycle commits that cycle's value
        wait_frame(cnt);
        tick(14);
        check("pre_bnd_an",  {12'd0, an}, 16'h0008);
        check("pre_bnd_seg", {9'd0, seg}, 16'h005B);
        do_load(16'hFFFF, 4'b0001);
        check("bnd_seg_old", {9'd0, seg},    16'h005B);
        check("bnd_frame",   {15'd0, frame}, 16'h0000);
        tick(1);
        check("bnd_new_frame", {15'd0, frame}, 16'h0001);
        check("bnd_new_an",    {12'd0, an},    16'h0001);
        check("bnd_new_seg",   {9'd0, seg},    16'h0071);
        check("bnd_new_dp",    {15'd0, dp},    16'h0001);
        tick(1);
        check("bnd_frame_drop", {15'd0, frame}, 16'h0000);
        tick(3);
        check("bnd_dig1_an",  {12'd0, an}, 16'h0002);
        check("bnd_dig1_seg", {9'd0, seg}, 16'h0071);
        check("bnd_dig1_dp",  {15'd0, dp}, 16'h0000);

        // Reset while a load is pending discards it
        tick(2);
        do_load(16'h8888, 4'b1111);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("mid_rst_an",    {12'd0, an},    16'h0000);
        check("mid_rst_seg",   {9'd0, seg},    16'h0000);
        check("mid_rst_dp",    {15'd0, dp},    16'h0000);
        check("mid_rst_frame", {15'd0, frame}, 16'h0000);
        rst = 1'b0;
        tick(1);
        check("resume_an",  {12'd0, an}, 16'h0001);
        check("resume_seg", {9'd0, seg}, 16'h003F);
        check("resume_dp",  {15'd0, dp}, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n_assert++;
            assert (seg !== 7'h7F && dp === 1'b0) else begin
                n_fail++;
                $error("FAIL no_8888: observed seg=%h dp=%b expected not 7F and dp 0", seg, dp);
            end
        end
        show_frame("zero", {ZSEG, ZSEG, ZSEG, 7'h3F}, 4'b0000);

        // Leading zeros: blanked (seg and dp) only when the feature is built in
        do_load(16'h0070, 4'b1111);
        show_frame("0070", {ZSEG, ZSEG, 7'h07, 7'h3F}, {ZDP, ZDP, 1'b1, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
